ac_match_reporter: RTL and testbench



---
 rtl/ac_match_reporter.sv | 163 ++++++++++++++++
 tb/tb_ac_match_reporter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ac_match_reporter.sv
// Aho-Corasick match reporter: maps each automaton state to a pattern mask and
// serialises every set bit into a {id, pos} record in a FWFT FIFO. Optional
// MATCH_STATE output is enabled with `define AC_MATCH_STATE_OUT_EN.
module ac_match_reporter #(
  parameter int STATE_W    = 8,
  parameter int DEPTH      = 32,
  parameter int NPAT       = 8,
  parameter int POS_W      = 16,
  parameter int FIFO_DEPTH = 8,
  // Contents of output_mask_output.txt, flattened: entry 0 in the LSBs.
  parameter logic [DEPTH*NPAT-1:0] TABLE_INIT = '0
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     EN,
  input  logic [STATE_W-1:0]       STATE_IN,
  input  logic                     STATE_VLD,
  output logic                     STATE_RDY,
  output logic                     MATCH_VLD,
  input  logic                     MATCH_RDY,
  output logic [$clog2(NPAT)-1:0]  MATCH_ID,
  output logic [POS_W-1:0]         MATCH_POS,
`ifdef AC_MATCH_STATE_OUT_EN
  output logic [STATE_W-1:0]       MATCH_STATE,
`endif
  output logic [POS_W-1:0]         MATCH_COUNT,
  output logic                     OVERFLOW,
  output logic                     BUSY
);

  localparam int ID_W  = $clog2(NPAT);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [POS_W-1:0] CNT_MAX = '1;
`ifdef AC_MATCH_STATE_OUT_EN
  localparam int REC_W = STATE_W + ID_W + POS_W;
`else
  localparam int REC_W = ID_W + POS_W;
`endif

  typedef enum logic {IDLE, SCAN} fsm_t;

  logic [NPAT-1:0]    rom [DEPTH];
  logic [REC_W-1:0]   fifo_mem [FIFO_DEPTH];

  fsm_t               state_q, state_d;
  logic [NPAT-1:0]    mask_q, mask_d;
  logic [POS_W-1:0]   pos_q, pos_d;
  logic [POS_W-1:0]   poscnt_q, poscnt_d;
  logic [POS_W-1:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic [AW:0]        wr_q, wr_d, rd_q, rd_d;
`ifdef AC_MATCH_STATE_OUT_EN
  logic [STATE_W-1:0] st_q, st_d;
`endif

  logic               in_range, empty, full, pop, push, accept, last_bit;
  logic [NPAT-1:0]    rom_mask;
  logic [ID_W-1:0]    low_id;
  logic [REC_W-1:0]   push_rec, head_rec;

  for (genvar g = 0; g < DEPTH; g++) begin : g_rom
    assign rom[g] = TABLE_INIT[g*NPAT +: NPAT];
  end

  always_comb begin
    in_range = (32'(STATE_IN) < DEPTH);
    rom_mask = in_range ? rom[STATE_IN[IDX_W-1:0]] : '0;
  end

  // Lowest set bit wins so records leave in ascending pattern-id order.
  always_comb begin
    low_id = '0;
    for (int i = NPAT - 1; i >= 0; i--) begin
      if (mask_q[i]) low_id = ID_W'(i);
    end
  end

  assign empty    = (wr_q == rd_q);
  assign full     = (wr_q[AW-1:0] == rd_q[AW-1:0]) && (wr_q[AW] != rd_q[AW]);
  assign pop      = ~empty & MATCH_RDY;
  assign push     = (state_q == SCAN) & EN & (~full | pop);
  assign accept   = STATE_VLD & STATE_RDY;
  assign last_bit = ((mask_q & (mask_q - 1'b1)) == '0);

`ifdef AC_MATCH_STATE_OUT_EN
  assign push_rec = {st_q, low_id, pos_q};
`else
  assign push_rec = {low_id, pos_q};
`endif
  assign head_rec = fifo_mem[rd_q[AW-1:0]];

  always_comb begin
    state_d  = state_q;
    mask_d   = mask_q;
    pos_d    = pos_q;
    poscnt_d = poscnt_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    wr_d     = wr_q;
    rd_d     = rd_q;
`ifdef AC_MATCH_STATE_OUT_EN
    st_d     = st_q;
`endif
    if (accept) begin
      pos_d    = poscnt_q;
      mask_d   = rom_mask;
      poscnt_d = poscnt_q + 1'b1;
      state_d  = (rom_mask != '0) ? SCAN : IDLE;
`ifdef AC_MATCH_STATE_OUT_EN
      st_d     = STATE_IN;
`endif
    end
    if (push) begin
      mask_d = mask_q & (mask_q - 1'b1);
      if (last_bit) state_d = IDLE;
      wr_d = wr_q + 1'b1;
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
      if (cnt_q == CNT_MAX - 1'b1) ovf_d = 1'b1;
    end
    if (pop) rd_d = rd_q + 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      poscnt_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      wr_q     <= '0;
      rd_q     <= '0;
    end else begin
      state_q  <= state_d;
      poscnt_q <= poscnt_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      wr_q     <= wr_d;
      rd_q     <= rd_d;
    end
  end

  // Data path: qualified by the FSM and FIFO pointers, so no reset needed.
  always_ff @(posedge CLK) begin
    mask_q <= mask_d;
    pos_q  <= pos_d;
`ifdef AC_MATCH_STATE_OUT_EN
    st_q   <= st_d;
`endif
    if (push) fifo_mem[wr_q[AW-1:0]] <= push_rec;
  end

  assign STATE_RDY   = EN & (state_q == IDLE);
  assign MATCH_VLD   = ~empty;
  assign MATCH_ID    = empty ? '0 : head_rec[POS_W +: ID_W];
  assign MATCH_POS   = empty ? '0 : head_rec[POS_W-1:0];
`ifdef AC_MATCH_STATE_OUT_EN
  assign MATCH_STATE = empty ? '0 : head_rec[REC_W-1 -: STATE_W];
`endif
  assign MATCH_COUNT = cnt_q;
  assign OVERFLOW    = ovf_q;
  assign BUSY        = (state_q == SCAN) | ~empty;

endmodule

// File: tb/tb_ac_match_reporter.sv
// Bench for ac_match_reporter: directed scenarios plus randomized traffic
// checked against a record-queue model of the match stream.
module tb_ac_match_reporter;

  localparam int STATE_W = 8;
  localparam int DEPTH   = 32;
  localparam int NPAT    = 8;
  localparam int POS_W   = 5;
  localparam int FDEPTH  = 8;
  localparam int SAT     = (1 << POS_W) - 1;

  function automatic logic [NPAT-1:0] tbl_f(input int s);
    if (s < 0 || s >= DEPTH) return '0;
    case (s)
      0:       return 8'h00;
      5:       return 8'h01;
      9:       return 8'h06;
      31:      return 8'hFF;
      default: return (s % 3 == 0) ? 8'h00 : 8'((s * 29 + 7) & 255);
    endcase
  endfunction

  function automatic logic [DEPTH*NPAT-1:0] mk_tbl();
    logic [DEPTH*NPAT-1:0] r;
    r = '0;
    for (int i = 0; i < DEPTH; i++) r[i*NPAT +: NPAT] = tbl_f(i);
    return r;
  endfunction

  localparam logic [DEPTH*NPAT-1:0] TBL = mk_tbl();

  logic               CLK = 1'b0;
  logic               RST, EN, STATE_VLD, MATCH_RDY;
  logic [STATE_W-1:0] STATE_IN;
  logic               STATE_RDY, MATCH_VLD, OVERFLOW, BUSY;
  logic [2:0]         MATCH_ID;
  logic [POS_W-1:0]   MATCH_POS, MATCH_COUNT;

  ac_match_reporter #(
    .STATE_W(STATE_W), .DEPTH(DEPTH), .NPAT(NPAT), .POS_W(POS_W),
    .FIFO_DEPTH(FDEPTH), .TABLE_INIT(TBL)
  ) dut (
    .CLK(CLK), .RST(RST), .EN(EN), .STATE_IN(STATE_IN), .STATE_VLD(STATE_VLD),
    .STATE_RDY(STATE_RDY), .MATCH_VLD(MATCH_VLD), .MATCH_RDY(MATCH_RDY),
    .MATCH_ID(MATCH_ID), .MATCH_POS(MATCH_POS), .MATCH_COUNT(MATCH_COUNT),
    .OVERFLOW(OVERFLOW), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [2:0]       id;
    logic [POS_W-1:0] pos;
  } rec_t;

  rec_t             expq[$];
  rec_t             r;
  logic [POS_W-1:0] mpos;
  int               total;
  int               nvec = 0;
  int               nfail = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    nvec++;
    if (obs !== exp) begin
      nfail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model: every accepted state expands into its set pattern bits
  // in ascending order at the next character position; pops must match.
  always @(negedge CLK) begin
    if (RST) begin
      expq.delete();
      mpos  = '0;
      total = 0;
    end else begin
      if (MATCH_VLD && MATCH_RDY) begin
        if (expq.size() == 0) chk("pop_unexpected", 1, 0);
        else begin
          r = expq.pop_front();
          chk("match_id", int'(MATCH_ID), int'(r.id));
          chk("match_pos", int'(MATCH_POS), int'(r.pos));
        end
      end
      if (STATE_VLD && STATE_RDY) begin
        for (int i = 0; i < NPAT; i++) begin
          if (tbl_f(int'(STATE_IN))[i]) begin
            expq.push_back('{id: 3'(i), pos: mpos});
            total++;
          end
        end
        mpos = mpos + 1'b1;
      end
    end
  end

  task automatic do_reset();
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
  endtask

  task automatic drive_state(input int s, output int stalls);
    bit ok;
    ok = 1'b0;
    stalls = 0;
    STATE_IN = STATE_W'(s);
    STATE_VLD = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge CLK);
      if (STATE_RDY) begin ok = 1'b1; break; end
      stalls++;
    end
    if (!ok) chk("accept_timeout", 0, 1);
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge CLK);
      if (!BUSY) begin ok = 1'b1; break; end
    end
    if (!ok) chk("idle_timeout", 0, 1);
    @(posedge CLK);
    #1;
  endtask

  task automatic check_counts(input string tag);
    chk({tag, "_count"}, int'(MATCH_COUNT), (total > SAT) ? SAT : total);
    chk({tag, "_ovf"}, int'(OVERFLOW), (total >= SAT) ? 1 : 0);
    chk({tag, "_drained"}, expq.size(), 0);
  endtask

  int st, st_sum;
  int r0, r1, r2;

  initial begin
    RST = 1'b1; EN = 1'b1; STATE_VLD = 1'b0; STATE_IN = '0; MATCH_RDY = 1'b0;
    do_reset();
    chk("rst_state_rdy", int'(STATE_RDY), 1);
    chk("rst_match_vld", int'(MATCH_VLD), 0);
    chk("rst_match_id", int'(MATCH_ID), 0);
    chk("rst_match_pos", int'(MATCH_POS), 0);
    chk("rst_count", int'(MATCH_COUNT), 0);
    chk("rst_ovf", int'(OVERFLOW), 0);
    chk("rst_busy", int'(BUSY), 0);

    // Single-bit state after two empty ones
    MATCH_RDY = 1'b1;
    st_sum = 0;
    drive_state(0, st); st_sum += st;
    drive_state(0, st); st_sum += st;
    drive_state(5, st); st_sum += st;
    STATE_VLD = 1'b0;
    chk("s5_no_stall", st_sum, 0);
    chk("s5_vld_lat0", int'(MATCH_VLD), 0);
    @(posedge CLK); #1;
    chk("s5_vld_lat1", int'(MATCH_VLD), 1);
    chk("s5_id", int'(MATCH_ID), 0);
    chk("s5_pos", int'(MATCH_POS), 2);
    wait_idle();
    chk("s5_count", int'(MATCH_COUNT), 1);

    // Two-bit state: ready low for exactly two cycles
    do_reset();
    drive_state(9, st);
    STATE_VLD = 1'b0;
    r0 = int'(STATE_RDY);
    @(posedge CLK); #1 r1 = int'(STATE_RDY);
    @(posedge CLK); #1 r2 = int'(STATE_RDY);
    chk("s9_rdy_c0", r0, 0);
    chk("s9_rdy_c1", r1, 0);
    chk("s9_rdy_c2", r2, 1);
    wait_idle();
    chk("s9_count", int'(MATCH_COUNT), 2);

    // FIFO fill with consumer stalled, then drain
    do_reset();
    MATCH_RDY = 1'b0;
    drive_state(31, st);
    drive_state(9, st);
    STATE_VLD = 1'b0;
    chk("full_s9_stalls", st, 8);
    repeat (5) @(posedge CLK);
    #1;
    chk("full_count", int'(MATCH_COUNT), 8);
    chk("full_state_rdy", int'(STATE_RDY), 0);
    chk("full_match_vld", int'(MATCH_VLD), 1);
    chk("full_busy", int'(BUSY), 1);
    MATCH_RDY = 1'b1;
    wait_idle();
    chk("full_count_final", int'(MATCH_COUNT), 10);
    check_counts("full");

    // Out-of-range state: no record, position still advances
    drive_state(40, st);
    drive_state(5, st);
    STATE_VLD = 1'b0;
    wait_idle();
    chk("oor_count", int'(MATCH_COUNT), 11);
    check_counts("oor");

    // Randomized traffic with enable and back-pressure
    for (int c = 0; c < 600; c++) begin
      EN        = ($urandom_range(0, 9) != 0);
      STATE_VLD = 1'($urandom_range(0, 1));
      STATE_IN  = STATE_W'($urandom_range(0, 47));
      MATCH_RDY = ($urandom_range(0, 3) != 0);
      @(posedge CLK); #1;
    end
    STATE_VLD = 1'b0; EN = 1'b1; MATCH_RDY = 1'b1;
    wait_idle();
    check_counts("rnd");

    // Counter saturation boundary
    do_reset();
    drive_state(31, st); drive_state(31, st); drive_state(31, st);
    drive_state(9, st);  drive_state(9, st);  drive_state(9, st);
    STATE_VLD = 1'b0;
    wait_idle();
    chk("sat30_count", int'(MATCH_COUNT), 30);
    chk("sat30_ovf", int'(OVERFLOW), 0);
    drive_state(5, st);
    STATE_VLD = 1'b0;
    wait_idle();
    chk("sat31_count", int'(MATCH_COUNT), SAT);
    chk("sat31_ovf", int'(OVERFLOW), 1);
    drive_state(5, st);
    STATE_VLD = 1'b0;
    wait_idle();
    chk("sat32_count", int'(MATCH_COUNT), SAT);
    chk("sat32_ovf", int'(OVERFLOW), 1);

    // Reset in the middle of a scan
    MATCH_RDY = 1'b0;
    drive_state(31, st);
    STATE_VLD = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    chk("mid_busy", int'(BUSY), 1);
    RST = 1'b1;
    @(posedge CLK); #1 RST = 1'b0;
    chk("mid_match_vld", int'(MATCH_VLD), 0);
    chk("mid_busy_after", int'(BUSY), 0);
    chk("mid_count", int'(MATCH_COUNT), 0);
    chk("mid_ovf", int'(OVERFLOW), 0);
    chk("mid_state_rdy", int'(STATE_RDY), 1);
    MATCH_RDY = 1'b1;
    drive_state(9, st);
    STATE_VLD = 1'b0;
    wait_idle();
    chk("mid_count_after", int'(MATCH_COUNT), 2);
    check_counts("mid");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
